// File: rtl/midi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : midi_pkg
// Description : Shared FSM state encoding and MIDI status-class boundaries
//               for the MIDI transmit queue.
// Revision    : 1.0 - initial release
// ============================================================================
package midi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_state_t;

  localparam logic [7:0] c_STATUS_BASE   = 8'h80;
  localparam logic [7:0] c_SYSCOM_BASE   = 8'hF0;
  localparam logic [7:0] c_REALTIME_BASE = 8'hF8;

  // Cycles WAIT_ACK tolerates without seeing the transmitter go busy.
  localparam logic [1:0] c_ACK_WAIT_CYCLES = 2'd3;

  function automatic logic is_channel_status(input logic [7:0] b);
    return (b >= c_STATUS_BASE) && (b < c_SYSCOM_BASE);
  endfunction

  function automatic logic is_system_common(input logic [7:0] b);
    return (b >= c_SYSCOM_BASE) && (b < c_REALTIME_BASE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/midi_tx_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : midi_tx_queue_if
// Description : Producer-side write port and UART-side load port of the
//               MIDI transmit queue.
// Revision    : 1.0 - initial release
// ============================================================================
interface midi_tx_queue_if #(
  parameter int DEPTH = 16
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              wr_strobe;
  logic [7:0]        wr_data;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              clr_ovf;
  logic              tx_busy;
  logic              tx_strobe;
  logic [7:0]        tx_data;

  modport master (
    output wr_strobe, wr_data, clr_ovf, tx_busy,
    input  full, count, overflow, tx_strobe, tx_data
  );

  modport slave (
    input  wr_strobe, wr_data, clr_ovf, tx_busy,
    output full, count, overflow, tx_strobe, tx_data
  );

endinterface
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : byte_fifo
// Description : Power-of-two byte FIFO with wrapping pointers; full/empty
//               are derived from the occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [7:0]        i_din,
  output logic [7:0]        o_dout,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_empty
);

  localparam logic [ADDR_W:0] c_FULL_COUNT = (ADDR_W+1)'(DEPTH);

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_push_ok;
  logic w_pop_ok;

  assign w_full    = (r_count == c_FULL_COUNT);
  assign w_empty   = (r_count == '0);
  // A push into a full FIFO is refused even when a pop frees a slot this cycle.
  assign w_push_ok = i_push && !w_full;
  assign w_pop_ok  = i_pop && !w_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule
`default_nettype wire

// File: rtl/midi_tx_queue.sv
`default_nettype none
// ============================================================================
// Module      : midi_tx_queue
// Description : Byte queue feeding a UART transmitter through a load/ack FSM.
//               Optional running-status suppression: MIDI_TX_RUNNING_STATUS_EN
// Revision    : 1.0 - initial release
// ============================================================================
module midi_tx_queue
  import midi_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  midi_tx_queue_if.slave  bus
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [7:0]      w_head;
  logic [ADDR_W:0] w_count;
  logic            w_full;
  logic            w_empty;
  logic            w_can_pop;
  logic            w_discard;

  tx_state_t       r_state;
  logic            r_tx_strobe;
  logic [7:0]      r_tx_data;
  logic [1:0]      r_ack_cnt;
  logic            r_overflow;

  byte_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (bus.wr_strobe),
    .i_pop   (w_can_pop),
    .i_din   (bus.wr_data),
    .o_dout  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_can_pop = (r_state == ST_IDLE) && !w_empty && !bus.tx_busy;

`ifdef MIDI_TX_RUNNING_STATUS_EN
  logic       r_rs_valid;
  logic [7:0] r_rs;

  // A repeated channel status is popped silently; the receiver reuses the last one.
  assign w_discard = r_rs_valid && is_channel_status(w_head) && (w_head == r_rs);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rs_valid <= 1'b0;
      r_rs       <= 8'h00;
    end else if (w_can_pop && !w_discard) begin
      if (is_channel_status(w_head)) begin
        r_rs_valid <= 1'b1;
        r_rs       <= w_head;
      end else if (is_system_common(w_head)) begin
        r_rs_valid <= 1'b0;
      end
    end
  end
`else
  assign w_discard = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_tx_strobe <= 1'b0;
      r_tx_data   <= 8'h00;
      r_ack_cnt   <= 2'd0;
    end else begin
      r_tx_strobe <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_can_pop && !w_discard) begin
            r_tx_data   <= w_head;
            r_tx_strobe <= 1'b1;
            r_state     <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          r_ack_cnt <= 2'd0;
          r_state   <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (bus.tx_busy) begin
            r_state <= ST_WAIT_DONE;
          end else if (r_ack_cnt == (c_ACK_WAIT_CYCLES - 2'd1)) begin
            // Transmitter never acknowledged; give up rather than stall the queue.
            r_state <= ST_IDLE;
          end else begin
            r_ack_cnt <= r_ack_cnt + 2'd1;
          end
        end
        ST_WAIT_DONE: begin
          if (!bus.tx_busy) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow <= 1'b0;
    end else if (bus.wr_strobe && w_full) begin
      r_overflow <= 1'b1;
    end else if (bus.clr_ovf) begin
      r_overflow <= 1'b0;
    end
  end

  assign bus.full      = w_full;
  assign bus.count     = w_count;
  assign bus.overflow  = r_overflow;
  assign bus.tx_strobe = r_tx_strobe;
  assign bus.tx_data   = r_tx_data;

endmodule
`default_nettype wire

// File: tb/tb_midi_tx_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_midi_tx_queue
// Description : Self-checking bench for midi_tx_queue with a UART responder
//               and a byte-stream reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_midi_tx_queue;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = $clog2(DEPTH);
  typedef logic [ADDR_W:0] cnt_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  midi_tx_queue_if #(.DEPTH(DEPTH)) bus ();

  midi_tx_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  longint     cyc   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  longint     st_times[$];
  int         m_rs  = -1;

  // UART responder: 0 = busy one cycle after strobe for 10 cycles, 1 = forced busy, 2 = never busy
  int         uart_mode = 0;
  logic [3:0] uart_cnt  = 4'd0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (uart_mode == 0 && bus.tx_strobe === 1'b1) uart_cnt <= 4'd10;
    else if (uart_cnt != 4'd0)                    uart_cnt <= uart_cnt - 4'd1;
  end
  assign bus.tx_busy = (uart_mode == 1) || (uart_cnt != 4'd0);

  logic       prev_strobe = 1'b0;
  logic [7:0] mon_e;
  always @(negedge clk) begin
    if (bus.tx_strobe === 1'b1) begin
      got_q.push_back(bus.tx_data);
      st_times.push_back(cyc);
      n_cmp++;
      if (bus.tx_busy !== 1'b0) begin
        n_err++; $display("FAIL strobe_while_busy: tx_busy=%b required 0", bus.tx_busy);
      end
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++; $display("FAIL unexpected_strobe: tx_data=%02h with nothing expected", bus.tx_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.tx_data !== mon_e) begin
          n_err++; $display("FAIL tx_order: got %02h required %02h", bus.tx_data, mon_e);
        end
      end
      n_cmp++;
      if (prev_strobe) begin
        n_err++; $display("FAIL strobe_width: tx_strobe high on consecutive cycles");
      end
    end
    prev_strobe <= (bus.tx_strobe === 1'b1);
  end

  // Reference stream: accepted bytes, minus repeated channel status when enabled.
  function automatic void model_accept(input logic [7:0] b);
`ifdef MIDI_TX_RUNNING_STATUS_EN
    if (b >= 8'h80 && b <= 8'hEF) begin
      if (m_rs == int'(b)) return;
      m_rs = int'(b);
    end else if (b >= 8'hF0 && b <= 8'hF7) begin
      m_rs = -1;
    end
`endif
    exp_q.push_back(b);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit acc);
    bus.wr_strobe = 1'b1;
    bus.wr_data   = b;
    tick();
    bus.wr_strobe = 1'b0;
    if (acc) model_accept(b);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    exp_q.delete();
    m_rs = -1;
    rst = 1'b1;
    tick();
  endtask

  task automatic wait_drain(input string tag);
    int k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      tick();
      k++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL %s_drain: %0d bytes never strobed, required 0", tag, exp_q.size());
      exp_q.delete();
    end
    repeat (20) tick();
    n_cmp++;
    if (bus.count !== cnt_t'(0)) begin
      n_err++; $display("FAIL %s_count_idle: count=%0d required 0", tag, bus.count);
    end
  endtask

  task automatic test_reset();
    bus.wr_strobe = 1'b0; bus.wr_data = 8'h00; bus.clr_ovf = 1'b0;
    rst = 1'b0;
    repeat (3) tick();
    n_cmp++; if (bus.count !== cnt_t'(0)) begin n_err++; $display("FAIL reset_count: got %0d required 0", bus.count); end
    n_cmp++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b required 0", bus.full); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b required 0", bus.overflow); end
    n_cmp++; if (bus.tx_strobe !== 1'b0) begin n_err++; $display("FAIL reset_strobe: got %b required 0", bus.tx_strobe); end
    n_cmp++; if (bus.tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data: got %02h required 00", bus.tx_data); end
    rst = 1'b1;
    repeat (2) tick();
    n_cmp++; if (bus.tx_strobe !== 1'b0) begin n_err++; $display("FAIL post_reset_strobe: got %b required 0", bus.tx_strobe); end
  endtask

  task automatic test_latency();
    logic [7:0] x, y;
    x = 8'($urandom_range(0, 127));
    y = 8'($urandom_range(0, 127));
    uart_mode = 0;
    got_q.delete();
    bus.wr_data = x; bus.wr_strobe = 1'b1;
    tick();
    model_accept(x);
    n_cmp++; if (bus.count !== cnt_t'(1)) begin n_err++; $display("FAIL lat_count_n: got %0d required 1", bus.count); end
    n_cmp++; if (bus.tx_strobe !== 1'b0) begin n_err++; $display("FAIL lat_strobe_n: got %b required 0", bus.tx_strobe); end
    bus.wr_data = y;
    tick();
    model_accept(y);
    bus.wr_strobe = 1'b0;
    n_cmp++; if (bus.count !== cnt_t'(1)) begin n_err++; $display("FAIL push_pop_count: got %0d required 1", bus.count); end
    n_cmp++; if (bus.tx_strobe !== 1'b1) begin n_err++; $display("FAIL lat_strobe_n1: got %b required 1", bus.tx_strobe); end
    n_cmp++; if (bus.tx_data !== x) begin n_err++; $display("FAIL lat_tx_data: got %02h required %02h", bus.tx_data, x); end
    wait_drain("latency");
    n_cmp++; if (got_q.size() != 2) begin n_err++; $display("FAIL lat_strobes: got %0d required 2", got_q.size()); end
  endtask

  task automatic test_uart_seq();
    logic [7:0] want[3] = '{8'h90, 8'h3C, 8'h40};
    uart_mode = 0;
    got_q.delete();
    for (int i = 0; i < 3; i++) push_byte(want[i], 1'b1);
    wait_drain("uart_seq");
    n_cmp++;
    if (got_q.size() != 3) begin
      n_err++; $display("FAIL uart_seq_len: got %0d required 3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (got_q[i] !== want[i]) begin n_err++; $display("FAIL uart_seq_byte%0d: got %02h required %02h", i, got_q[i], want[i]); end
      end
    end
  endtask

  task automatic test_no_ack();
    int k = 0;
    uart_mode = 2;
    got_q.delete();
    st_times.delete();
    push_byte(8'($urandom_range(0, 127)), 1'b1);
    push_byte(8'($urandom_range(0, 127)), 1'b1);
    while (st_times.size() < 2 && k < 100) begin tick(); k++; end
    n_cmp++;
    if (st_times.size() < 2) begin
      n_err++; $display("FAIL no_ack_strobes: got %0d required 2", st_times.size());
    end else begin
      n_cmp++;
      if (st_times[1] - st_times[0] != 5) begin
        n_err++; $display("FAIL no_ack_gap: got %0d cycles required 5", st_times[1] - st_times[0]);
      end
    end
    wait_drain("no_ack");
    uart_mode = 0;
  endtask

  task automatic test_overflow();
    uart_mode = 1;
    got_q.delete();
    for (int i = 0; i < DEPTH; i++) push_byte(8'($urandom), 1'b1);
    n_cmp++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL ovf_full: got %b required 1", bus.full); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %b required 0", bus.overflow); end
    push_byte(8'($urandom), 1'b0);
    n_cmp++; if (bus.count !== cnt_t'(DEPTH)) begin n_err++; $display("FAIL ovf_count: got %0d required %0d", bus.count, DEPTH); end
    n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b required 1", bus.overflow); end
    bus.clr_ovf = 1'b1;
    push_byte(8'($urandom), 1'b0);
    bus.clr_ovf = 1'b0;
    n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_clr_vs_drop: got %b required 1", bus.overflow); end
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b required 0", bus.overflow); end
    n_cmp++; if (got_q.size() != 0) begin n_err++; $display("FAIL ovf_busy_strobes: got %0d required 0", got_q.size()); end
    uart_mode = 0;
    wait_drain("overflow");
    n_cmp++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL ovf_drained_full: got %b required 0", bus.full); end
  endtask

  task automatic test_random();
    uart_mode = 0;
    for (int burst = 0; burst < 6; burst++) begin
      int n = $urandom_range(1, DEPTH - 2);
      for (int i = 0; i < n; i++) begin
        push_byte(8'($urandom), 1'b1);
        repeat ($urandom_range(0, 2)) tick();
      end
      wait_drain("random");
    end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL random_overflow: got %b required 0", bus.overflow); end
  endtask

`ifdef MIDI_TX_RUNNING_STATUS_EN
  task automatic test_running_status();
    logic [7:0] in_a[6]  = '{8'h90, 8'h3C, 8'h40, 8'h90, 8'h3E, 8'h40};
    logic [7:0] out_a[5] = '{8'h90, 8'h3C, 8'h40, 8'h3E, 8'h40};
    logic [7:0] in_b[5]  = '{8'h90, 8'hF8, 8'h90, 8'hF0, 8'h90};
    logic [7:0] out_b[4] = '{8'h90, 8'hF8, 8'hF0, 8'h90};
    uart_mode = 0;
    do_reset();
    got_q.delete();
    for (int i = 0; i < 6; i++) push_byte(in_a[i], 1'b1);
    wait_drain("rs_a");
    n_cmp++;
    if (got_q.size() != 5) begin n_err++; $display("FAIL rs_a_len: got %0d required 5", got_q.size()); end
    else for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (got_q[i] !== out_a[i]) begin n_err++; $display("FAIL rs_a_byte%0d: got %02h required %02h", i, got_q[i], out_a[i]); end
    end
    do_reset();
    got_q.delete();
    for (int i = 0; i < 5; i++) push_byte(in_b[i], 1'b1);
    wait_drain("rs_b");
    n_cmp++;
    if (got_q.size() != 4) begin n_err++; $display("FAIL rs_b_len: got %0d required 4", got_q.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got_q[i] !== out_b[i]) begin n_err++; $display("FAIL rs_b_byte%0d: got %02h required %02h", i, got_q[i], out_b[i]); end
    end
  endtask
`endif

  task automatic test_reset_mid();
    int k = 0;
    int n_before;
    uart_mode = 0;
    got_q.delete();
    for (int i = 0; i < 6; i++) push_byte(8'($urandom_range(0, 127)), 1'b1);
    while (bus.tx_busy !== 1'b1 && k < 50) begin tick(); k++; end
    repeat (2) tick();
    n_cmp++; if (bus.count !== cnt_t'(5)) begin n_err++; $display("FAIL mid_count_before: got %0d required 5", bus.count); end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.count !== cnt_t'(0)) begin n_err++; $display("FAIL mid_reset_count: got %0d required 0", bus.count); end
    n_cmp++; if (bus.tx_strobe !== 1'b0) begin n_err++; $display("FAIL mid_reset_strobe: got %b required 0", bus.tx_strobe); end
    n_cmp++; if (bus.tx_data !== 8'h00) begin n_err++; $display("FAIL mid_reset_tx_data: got %02h required 00", bus.tx_data); end
    exp_q.delete();
    m_rs = -1;
    n_before = got_q.size();
    tick();
    rst = 1'b1;
    repeat (30) tick();
    n_cmp++; if (got_q.size() != n_before) begin n_err++; $display("FAIL mid_reset_strobes: got %0d extra strobes required 0", got_q.size() - n_before); end
    n_cmp++; if (n_before != 1) begin n_err++; $display("FAIL mid_first_strobe: got %0d strobes before reset required 1", n_before); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_uart_seq();
    test_no_ack();
    test_overflow();
    test_random();
`ifdef MIDI_TX_RUNNING_STATUS_EN
    test_running_status();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
